// File: rtl/stream_splitter_pkg.sv
// Shared definitions for stream_splitter.
//   state_e    : FSM state encoding (StIdle = no word held, StShift = emitting lanes)
//   DefaultWidth / DefaultLane : default word and lane widths
//   cnt_width  : width of the lane counter / out_idx for a given lane count
package stream_splitter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultLane  = 8;

  // Width of the lane counter and out_idx; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned nlanes);
    return (nlanes <= 2) ? 1 : $clog2(nlanes);
  endfunction

endpackage

// File: rtl/stream_splitter.sv
// stream_splitter: accepts one WIDTH-bit word over valid/ready and emits it as
// WIDTH/LANE lanes of LANE bits, one lane per accepted output beat. Lane order
// (LSB-lane first or MSB-lane first) is chosen per word by msb_first.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_valid   in   producer presents a word
//   in_ready   out  word accepted this cycle (combinational from out_ready)
//   in_data    in   WIDTH-bit word
//   msb_first  in   lane order, sampled with the word
//   out_valid  out  out_data holds a valid lane
//   out_ready  in   consumer takes the lane
//   out_data   out  current lane
//   out_idx    out  lane position within the word (0 = least-significant)
//   out_last   out  current lane is the final lane of the word
//   words_done out  16-bit wrapping count of completed words
//                   (present only when STREAM_SPLITTER_COUNT_EN is defined)
module stream_splitter
  import stream_splitter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned LANE  = DefaultLane,
  localparam int unsigned NLANES = WIDTH / LANE,
  localparam int unsigned IdxW   = cnt_width(NLANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANE-1:0]  out_data,
  output logic [IdxW-1:0]  out_idx,
  output logic             out_last
`ifdef STREAM_SPLITTER_COUNT_EN
  ,
  output logic [15:0]      words_done
`endif
);

  // Elaboration-time parameter sanity.
  if (LANE == 0 || (WIDTH % LANE) != 0) begin : g_bad_lane
    $error("stream_splitter: WIDTH must be a non-zero multiple of LANE");
  end
  if (NLANES < 2) begin : g_bad_nlanes
    $error("stream_splitter: WIDTH/LANE must be at least 2");
  end

  localparam logic [IdxW-1:0] LastCnt = IdxW'(NLANES - 1);

  state_e           state_q;
  logic [IdxW-1:0]  cnt_q;
  logic [WIDTH-1:0] word_q;
  logic             mode_q;
  logic             last_q;

  logic out_fire;
  logic in_fire;

  assign out_valid = (state_q == StShift);
  assign out_last  = last_q;
  assign out_fire  = out_valid && out_ready;

  // Accept in IDLE, or while the last lane leaves so words run back-to-back.
  assign in_ready = !reset && ((state_q == StIdle) || (out_fire && last_q));
  assign in_fire  = in_valid && in_ready;

  assign out_idx  = mode_q ? (LastCnt - cnt_q) : cnt_q;
  assign out_data = word_q[out_idx * LANE +: LANE];

  // last_q mirrors (cnt_q == LastCnt) while in StShift and is 0 in StIdle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      word_q  <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_fire) begin
            word_q  <= in_data;
            mode_q  <= msb_first;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (in_fire) begin
            // Last lane consumed and next word taken in the same cycle.
            word_q  <= in_data;
            mode_q  <= msb_first;
            cnt_q   <= '0;
            last_q  <= 1'b0;
          end else if (out_fire) begin
            if (last_q) begin
              cnt_q   <= '0;
              last_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q  <= cnt_q + IdxW'(1);
              last_q <= ((cnt_q + IdxW'(1)) == LastCnt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef STREAM_SPLITTER_COUNT_EN
  logic [15:0] words_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_done_q <= '0;
    end else if (out_fire && last_q) begin
      words_done_q <= words_done_q + 16'd1;
    end
  end

  assign words_done = words_done_q;
`endif

endmodule

// File: tb/tb_stream_splitter.sv
// Self-checking bench for stream_splitter (WIDTH=32, LANE=8).
// The expected lane sequence of each accepted word is pushed into a queue;
// a negedge monitor pops and compares whenever the DUT presents a lane.
module tb_stream_splitter;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 8;
  localparam int unsigned NL = W / L;

  typedef struct packed {
    logic [L-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         msb_first = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [L-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;
`ifdef STREAM_SPLITTER_COUNT_EN
  logic [15:0]  words_done;
  logic [15:0]  done_cnt = '0;
`endif

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  stim_done = 1'b0;

  always #5 clk = ~clk;

  stream_splitter #(
    .WIDTH(W),
    .LANE (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef STREAM_SPLITTER_COUNT_EN
    ,
    .words_done(words_done)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at t=%0t", name, $time);
  endtask

  // Reference model: an accepted word becomes NL lanes in the requested order.
  // A word is accepted whenever the model holds nothing and in_valid is high.
  always @(posedge clk) begin
    if (!reset && in_valid && exp_q.size() == 0) begin
      for (int k = 0; k < NL; k++) begin
        beat_t b;
        int    pos;
        pos    = msb_first ? (NL - 1 - k) : k;
        b.data = L'(in_data >> (pos * L));
        b.idx  = 2'(pos);
        b.last = (k == NL - 1);
        exp_q.push_back(b);
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_data", out_data, 0);
`ifdef STREAM_SPLITTER_COUNT_EN
      check("rst_words_done", words_done, 0);
      done_cnt = '0;
`endif
    end else begin
      check("in_ready", in_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
      check("out_valid", out_valid, exp_q.size() != 0);
`ifdef STREAM_SPLITTER_COUNT_EN
      check("words_done", words_done, done_cnt);
`endif
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        check("out_data", out_data, b.data);
        check("out_idx", out_idx, b.idx);
        check("out_last", out_last, b.last);
        if (out_ready) begin
          void'(exp_q.pop_front());
`ifdef STREAM_SPLITTER_COUNT_EN
          if (b.last) done_cnt = done_cnt + 16'd1;
`endif
        end
      end
    end
  end

  // Present a word and hold it until the DUT takes it; returns just after the
  // accepting edge with in_valid still high.
  task automatic send(input logic [W-1:0] w, input logic m);
    in_valid  = 1'b1;
    in_data   = w;
    msb_first = m;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_now("drain_timeout");
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;

    // LSB-first, then MSB-first.
    send(32'h12345678, 1'b0);
    in_valid = 1'b0;
    drain();
    send(32'h12345678, 1'b1);
    in_valid = 1'b0;
    drain();

    // Back-to-back words with in_valid held high.
    send(32'h12345678, 1'b0);
    send(32'hA1B2C3D4, 1'b0);
    in_valid = 1'b0;
    drain();

    // Stall on the second lane while in_data churns.
    send(32'h12345678, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    msb_first = 1'b1;
    @(posedge clk);
    #1;
    in_data   = $urandom;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain();

    // Reset after two lanes have been consumed.
    send(32'hCAFEF00D, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic with random consumer back-pressure.
    fork
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          send($urandom, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
          end
        end
        in_valid  = 1'b0;
        stim_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
